crc16_rx_check: RTL and testbench

Receive-side CRC16 checker for USB DATA packets. It sits between the bit-unstuffer and the receive protocol handler and accepts an LSB-first serial stream: 8-bit PID, 64-bit payload, then 16 CRC bits. It deserializes PID and payload into a 72-bit word and runs the USB CRC16 LFSR over the payload bits. It compares the received CRC field against the complemented remainder and reports pass/fail when end-of-packet arrives. It is the counterpart of the transmit CRC16 generator.

---
 rtl/usb_pkg.sv | 34 +++
 rtl/crc16_rx_fsm.sv | 135 +++++++++++++
 rtl/crc16_rx_check.sv | 106 ++++++++++
 tb/tb_crc16_rx_check.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// ============================================================================
// usb_pkg : shared USB packet lengths, CRC16 LFSR step and rx state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package usb_pkg;

  localparam int PID_LEN = 8;
  localparam int PKT_LEN = 72;
  localparam int CRC_LEN = 16;

  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
  // Feedback lands in x0 (via the shift), x2 and x15: x^16 + x^15 + x^2 + 1
  localparam logic [15:0] CRC16_TAPS   = 16'h8004;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_PID   = 3'd1,
    RX_DATA  = 3'd2,
    RX_CRC   = 3'd3,
    WAIT_EOP = 3'd4,
    ERR_WAIT = 3'd5
  } rx_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], fb} ^ (fb ? CRC16_TAPS : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc16_rx_fsm.sv
// ============================================================================
// crc16_rx_fsm : packet-phase state register and verdict decode for the
//                CRC16 receive checker. Rev 1.0
// ============================================================================
`default_nettype none

module crc16_rx_fsm
  import usb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic pkt_start,
  input  logic bit_valid,
  input  logic eop,
  input  logic pid_last,
  input  logic data_last,
  input  logic crc_last,
  input  logic mismatch,
  output logic in_pid,
  output logic in_data,
  output logic in_crc,
  output logic pkt_done,
  output logic crc_ok,
  output logic len_err
);

  rx_state_e state_q, state_d;
  logic      pkt_done_q, pkt_done_d;
  logic      crc_ok_q, crc_ok_d;
  logic      len_err_q, len_err_d;

  always_comb begin
    state_d    = state_q;
    pkt_done_d = 1'b0;
    crc_ok_d   = crc_ok_q;
    len_err_d  = len_err_q;

    // A start pulse wins over everything, including a coincident eop.
    if (pkt_start) begin
      state_d   = RX_PID;
      crc_ok_d  = 1'b0;
      len_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RX_PID: begin
          if (eop) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            crc_ok_d   = 1'b0;
            len_err_d  = 1'b1;
          end else if (bit_valid && pid_last) begin
            state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (eop) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            crc_ok_d   = 1'b0;
            len_err_d  = 1'b1;
          end else if (bit_valid && data_last) begin
            state_d = RX_CRC;
          end
        end
        RX_CRC: begin
          // The bit in this cycle is counted before eop is judged.
          if (eop) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            if (bit_valid && crc_last) begin
              crc_ok_d  = ~mismatch;
              len_err_d = 1'b0;
            end else begin
              crc_ok_d  = 1'b0;
              len_err_d = 1'b1;
            end
          end else if (bit_valid && crc_last) begin
            state_d = WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          if (bit_valid) begin
            if (eop) begin
              state_d    = IDLE;
              pkt_done_d = 1'b1;
              crc_ok_d   = 1'b0;
              len_err_d  = 1'b1;
            end else begin
              state_d = ERR_WAIT;
            end
          end else if (eop) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            crc_ok_d   = ~mismatch;
            len_err_d  = 1'b0;
          end
        end
        ERR_WAIT: begin
          if (eop) begin
            state_d    = IDLE;
            pkt_done_d = 1'b1;
            crc_ok_d   = 1'b0;
            len_err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pkt_done_q <= 1'b0;
      crc_ok_q   <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_done_q <= pkt_done_d;
      crc_ok_q   <= crc_ok_d;
      len_err_q  <= len_err_d;
    end
  end

  assign in_pid   = (state_q == RX_PID);
  assign in_data  = (state_q == RX_DATA);
  assign in_crc   = (state_q == RX_CRC);
  assign pkt_done = pkt_done_q;
  assign crc_ok   = crc_ok_q;
  assign len_err  = len_err_q;

endmodule

`default_nettype wire

// File: rtl/crc16_rx_check.sv
// ============================================================================
// crc16_rx_check : USB DATA packet deserializer and CRC16 receive checker
// Rev 1.0
// ============================================================================
`default_nettype none

module crc16_rx_check
  import usb_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pkt_start,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               eop,
  output logic [PKT_LEN-1:0] pkt_out,
  output logic               pkt_done,
  output logic               crc_ok,
  output logic               len_err
);

  logic [PKT_LEN-1:0] pkt_out_q, pkt_out_d;
  logic [6:0]         bit_cnt_q, bit_cnt_d;
  logic [4:0]         crc_cnt_q, crc_cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               mismatch_q, mismatch_d;

  logic               in_pid, in_data, in_crc;
  logic               pid_last, data_last, crc_last;
  logic [3:0]         crc_idx;

  assign pid_last  = (bit_cnt_q == 7'(PID_LEN - 1));
  assign data_last = (bit_cnt_q == 7'(PKT_LEN - 1));
  assign crc_last  = (crc_cnt_q == 5'(CRC_LEN - 1));
  // CRC field goes out complemented, MSB of the register first.
  assign crc_idx   = 4'd15 - crc_cnt_q[3:0];

  always_comb begin
    pkt_out_d  = pkt_out_q;
    bit_cnt_d  = bit_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    lfsr_d     = lfsr_q;
    mismatch_d = mismatch_q;

    if (pkt_start) begin
      pkt_out_d  = '0;
      bit_cnt_d  = '0;
      crc_cnt_d  = '0;
      lfsr_d     = CRC16_PRESET;
      mismatch_d = 1'b0;
    end else if (bit_valid) begin
      if (in_pid || in_data) begin
        pkt_out_d = {bit_in, pkt_out_q[PKT_LEN-1:1]};
        bit_cnt_d = bit_cnt_q + 7'd1;
      end
      if (in_data) begin
        lfsr_d = crc16_step(lfsr_q, bit_in);
      end
      if (in_crc) begin
        crc_cnt_d = crc_cnt_q + 5'd1;
        if (bit_in != ~lfsr_q[crc_idx]) begin
          mismatch_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_out_q  <= '0;
      bit_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      lfsr_q     <= CRC16_PRESET;
      mismatch_q <= 1'b0;
    end else begin
      pkt_out_q  <= pkt_out_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      lfsr_q     <= lfsr_d;
      mismatch_q <= mismatch_d;
    end
  end

  crc16_rx_fsm u_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .pkt_start (pkt_start),
    .bit_valid (bit_valid),
    .eop       (eop),
    .pid_last  (pid_last),
    .data_last (data_last),
    .crc_last  (crc_last),
    .mismatch  (mismatch_d),
    .in_pid    (in_pid),
    .in_data   (in_data),
    .in_crc    (in_crc),
    .pkt_done  (pkt_done),
    .crc_ok    (crc_ok),
    .len_err   (len_err)
  );

  assign pkt_out = pkt_out_q;

endmodule

`default_nettype wire

// File: tb/tb_crc16_rx_check.sv
// ============================================================================
// tb_crc16_rx_check : directed and random packets against a CRC-16/USB model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_crc16_rx_check;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        eop = 1'b0;
  logic [71:0] pkt_out;
  logic        pkt_done, crc_ok, len_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic bits [0:95];

  localparam logic [7:0]  GOLD_PID = 8'hC3;
  localparam logic [63:0] GOLD_PAY = 64'h0123456789ABCDEF;

  crc16_rx_check dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pkt_start (pkt_start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .eop       (eop),
    .pkt_out   (pkt_out),
    .pkt_done  (pkt_done),
    .crc_ok    (crc_ok),
    .len_err   (len_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (pkt_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Standard reflected CRC-16/USB over payload bytes, sent LSB first.
  function automatic logic [15:0] usb_crc16(input logic [63:0] pay);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int by = 0; by < 8; by++) begin
      c = c ^ {8'h00, pay[by*8 +: 8]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [7:0] pid, input logic [63:0] pay);
    logic [15:0] c;
    c = usb_crc16(pay);
    for (int i = 0; i < 8; i++)  bits[i] = pid[i];
    for (int i = 0; i < 64; i++) bits[8+i] = pay[i];
    for (int i = 0; i < 16; i++) bits[72+i] = c[i];
    for (int i = 88; i < 96; i++) bits[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic model(input int n, output logic ok, output logic le, output logic [71:0] eo);
    logic [63:0] p;
    logic [15:0] r;
    int m;
    m  = (n < 72) ? n : 72;
    eo = '0;
    for (int k = 0; k < m; k++) eo[72-m+k] = bits[k];
    if (n != 88) begin
      ok = 1'b0;
      le = 1'b1;
    end else begin
      for (int i = 0; i < 64; i++) p[i] = bits[8+i];
      for (int i = 0; i < 16; i++) r[i] = bits[72+i];
      ok = (r == usb_crc16(p));
      le = 1'b0;
    end
  endtask

  task automatic drive_idle();
    @(negedge clock);
    pkt_start = 1'b0;
    bit_valid = 1'b0;
    eop       = 1'b0;
    bit_in    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start();
    @(negedge clock);
    pkt_start = 1'b1;
    bit_valid = 1'b0;
    eop       = 1'b0;
  endtask

  task automatic send_bits(input int n, input int gap, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0 && (i % gap) == 0) drive_idle();
      else if (gap < 0 && $urandom_range(0, 3) == 0) drive_idle();
      @(negedge clock);
      pkt_start = 1'b0;
      bit_in    = bits[i];
      bit_valid = 1'b1;
      eop       = eop_last && (i == n - 1);
    end
  endtask

  task automatic finish_check(input string tag, input int n, input bit eop_last);
    logic ok, le;
    logic [71:0] eo;
    model(n, ok, le, eo);
    if (!eop_last) begin
      @(negedge clock);
      pkt_start = 1'b0;
      bit_valid = 1'b0;
      eop       = 1'b1;
    end
    @(negedge clock);
    eop       = 1'b0;
    bit_valid = 1'b0;
    chk({tag, ".done"},   {71'd0, pkt_done}, 72'd1);
    chk({tag, ".crc_ok"}, {71'd0, crc_ok},   {71'd0, ok});
    chk({tag, ".len_err"},{71'd0, len_err},  {71'd0, le});
    chk({tag, ".pkt_out"}, pkt_out, eo);
    @(negedge clock);
    chk({tag, ".pulse"},  {71'd0, pkt_done}, 72'd0);
    chk({tag, ".hold"},   {71'd0, crc_ok},   {71'd0, ok});
  endtask

  task automatic run_packet(input string tag, input logic [7:0] pid, input logic [63:0] pay,
                            input int n, input int flip, input int gap, input bit eop_last);
    build(pid, pay);
    if (flip >= 0) bits[flip] = ~bits[flip];
    do_start();
    send_bits(n, gap, eop_last);
    finish_check(tag, n, eop_last);
  endtask

  initial begin
    int d0;
    int n, flip, r;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst.pkt_out",  pkt_out, 72'd0);
    chk("rst.pkt_done", {71'd0, pkt_done}, 72'd0);
    chk("rst.crc_ok",   {71'd0, crc_ok},   72'd0);
    chk("rst.len_err",  {71'd0, len_err},  72'd0);
    reset_n = 1'b1;
    drive_idle();

    run_packet("gold", GOLD_PID, GOLD_PAY, 88, -1, 0, 1'b0);
    chk("gold.word", pkt_out, {GOLD_PAY, GOLD_PID});
    chk("gold.ok",   {71'd0, crc_ok}, 72'd1);

    run_packet("gaps", GOLD_PID, GOLD_PAY, 88, -1, 6, 1'b0);
    chk("gaps.word", pkt_out, {GOLD_PAY, GOLD_PID});

    run_packet("flip_pay20", GOLD_PID, GOLD_PAY, 88, 8 + 20, 0, 1'b0);
    chk("flip_pay20.ok", {71'd0, crc_ok}, 72'd0);
    chk("flip_pay20.le", {71'd0, len_err}, 72'd0);

    run_packet("flip_crc15", GOLD_PID, GOLD_PAY, 88, 72 + 15, 0, 1'b0);
    chk("flip_crc15.ok", {71'd0, crc_ok}, 72'd0);

    run_packet("early50", GOLD_PID, GOLD_PAY, 50, -1, 0, 1'b0);
    chk("early50.le", {71'd0, len_err}, 72'd1);

    run_packet("overrun", GOLD_PID, GOLD_PAY, 89, -1, 0, 1'b0);
    chk("overrun.le", {71'd0, len_err}, 72'd1);

    run_packet("eop_with88", GOLD_PID, GOLD_PAY, 88, -1, 0, 1'b1);
    chk("eop_with88.ok", {71'd0, crc_ok}, 72'd1);

    run_packet("eop_with72", GOLD_PID, GOLD_PAY, 72, -1, 0, 1'b1);

    // Abort at bit 30, then a full packet: exactly one verdict
    d0 = done_cnt;
    build(GOLD_PID, ~GOLD_PAY);
    do_start();
    send_bits(30, 0, 1'b0);
    run_packet("restart", GOLD_PID, GOLD_PAY, 88, -1, 0, 1'b0);
    drive_idle();
    chk("restart.ndone", 72'(done_cnt - d0), 72'd1);
    chk("restart.ok", {71'd0, crc_ok}, 72'd1);

    // eop while idle is ignored
    d0 = done_cnt;
    @(negedge clock);
    eop = 1'b1;
    drive_idle();
    drive_idle();
    chk("idle_eop.ndone", 72'(done_cnt - d0), 72'd0);
    chk("idle_eop.ok", {71'd0, crc_ok}, 72'd1);

    // Async reset at bit 40
    d0 = done_cnt;
    build($urandom_range(0, 255), {$urandom, $urandom});
    do_start();
    send_bits(40, 0, 1'b0);
    @(negedge clock);
    bit_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("arst.pkt_out",  pkt_out, 72'd0);
    chk("arst.pkt_done", {71'd0, pkt_done}, 72'd0);
    chk("arst.crc_ok",   {71'd0, crc_ok},   72'd0);
    chk("arst.len_err",  {71'd0, len_err},  72'd0);
    @(negedge clock);
    reset_n = 1'b1;
    eop     = 1'b1;
    drive_idle();
    drive_idle();
    chk("arst.ndone", 72'(done_cnt - d0), 72'd0);

    // Random packets with random gaps, lengths and corruption
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       n = 88;
      else if (r == 6) n = $urandom_range(1, 87);
      else if (r == 7) n = $urandom_range(89, 92);
      else             n = 88;
      flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 87)) : -1;
      run_packet($sformatf("rand%0d", t), 8'($urandom_range(0, 255)), {$urandom, $urandom},
                 n, flip, -1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
